pzcorebus_request_m_to_1_arbiter: RTL and testbench

- Request-path companion to the response m-to-1 switch. Merges N slave-side request ports (command + write data) onto one master-side request port using round-robin arbitration.
- Stamps the winning port index into the command ID so the returned response SID can be decoded back to that port by the response switch.
- Holds the grant across a complete write-data burst so commands and data are never interleaved between ports.

---
 rtl/pzcorebus_pkg.sv | 37 +++
 rtl/pzcorebus_request_m_to_1_arbiter_round_robin_grant.sv | 52 +++++
 rtl/pzcorebus_request_m_to_1_arbiter.sv | 199 +++++++++++++++++++
 tb/tb_pzcorebus_request_m_to_1_arbiter.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/pzcorebus_pkg.sv
// pzcorebus shared types: bus configuration, command encoding, request
// arbiter state and a command classification helper.
package pzcorebus_pkg;

  typedef struct packed {
    int id_width;
    int address_width;
    int data_width;
  } pzcorebus_config;

  localparam pzcorebus_config PZCOREBUS_DEFAULT_CONFIG = '{
    id_width:      8,
    address_width: 32,
    data_width:    32
  };

  localparam int PZCOREBUS_COMMAND_WIDTH = 3;

  typedef enum logic [2:0] {
    PZCOREBUS_READ             = 3'b000,
    PZCOREBUS_WRITE            = 3'b001,
    PZCOREBUS_WRITE_NON_POSTED = 3'b011,
    PZCOREBUS_MESSAGE          = 3'b100
  } pzcorebus_command_type;

  typedef enum logic [1:0] {
    ARB  = 2'd0,
    CMD  = 2'd1,
    DATA = 2'd2
  } pzcorebus_arbiter_state;

  // Commands that carry a write-data burst.
  function automatic logic is_write_command(input logic [PZCOREBUS_COMMAND_WIDTH-1:0] mcmd);
    return (mcmd == PZCOREBUS_WRITE) || (mcmd == PZCOREBUS_WRITE_NON_POSTED);
  endfunction

endpackage

// File: rtl/pzcorebus_request_m_to_1_arbiter_round_robin_grant.sv
// pzcorebus_round_robin_grant: round-robin pointer plus wrap-around priority
// search. The pointer moves to (winner+1) mod N only on a release pulse.
module pzcorebus_round_robin_grant #(
  parameter int N = 2,
  parameter int W = $clog2(N)
)(
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic [N-1:0] i_request,
  input  logic         i_release,
  output logic [N-1:0] o_grant,
  output logic [W-1:0] o_index
);

  logic [W-1:0] pointer_r;
  logic [W-1:0] cand_s;
  logic         found_s;

  // First requester at or above the pointer, wrapping past N-1 back to 0.
  always_comb begin
    o_grant = '0;
    o_index = '0;
    found_s = 1'b0;
    cand_s  = '0;
    for (int k = 0; k < N; k++) begin
      cand_s = W'((int'(pointer_r) + k) % N);
      if (!found_s && i_request[cand_s]) begin
        found_s          = 1'b1;
        o_index          = cand_s;
        o_grant[cand_s]  = 1'b1;
      end else begin
        found_s = found_s;
      end
    end
  end

  // Advance the pointer past the released winner, wrapping at N-1.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      pointer_r <= '0;
    end else if (i_release) begin
      if (o_index == W'(N - 1)) begin
        pointer_r <= '0;
      end else begin
        pointer_r <= o_index + W'(1);
      end
    end else begin
      pointer_r <= pointer_r;
    end
  end

endmodule

// File: rtl/pzcorebus_request_m_to_1_arbiter.sv
// pzcorebus_request_m_to_1_arbiter: merges SLAVES request ports onto one
// master request port with round-robin arbitration. The winning port index
// is stamped into mid so the response switch can route the reply back, and
// the grant is held across the whole write-data burst.
// The slave/master request views are carried as flattened per-port arrays.
// Optional: define PZCOREBUS_REQUEST_ARBITER_STATS_EN to add per-port
// saturating accepted-command counters (o_grant_count, cleared by
// i_stats_clear).
module pzcorebus_request_m_to_1_arbiter
  import pzcorebus_pkg::*;
#(
  parameter pzcorebus_config BUS_CONFIG      = PZCOREBUS_DEFAULT_CONFIG,
  parameter int              SLAVES          = 2,
  parameter int              SELECT_WIDTH    = $clog2(SLAVES),
  parameter int              SELECT_LSB      = BUS_CONFIG.id_width - SELECT_WIDTH,
  parameter bit              EXTERNAL_ENCODE = 1'b0
)(
  input  logic                                                  i_clk,
  input  logic                                                  i_rst_n,
`ifdef PZCOREBUS_REQUEST_ARBITER_STATS_EN
  input  logic                                                  i_stats_clear,
  output logic [SLAVES-1:0][15:0]                               o_grant_count,
`endif
  output logic [SELECT_WIDTH-1:0]                               o_grant_index,
  output logic                                                  o_busy,
  // upstream (request_slave) ports
  input  logic [SLAVES-1:0]                                     slave_mcmd_valid,
  input  logic [SLAVES-1:0][PZCOREBUS_COMMAND_WIDTH-1:0]        slave_mcmd,
  input  logic [SLAVES-1:0][BUS_CONFIG.id_width-1:0]            slave_mid,
  input  logic [SLAVES-1:0][BUS_CONFIG.address_width-1:0]       slave_maddr,
  output logic [SLAVES-1:0]                                     slave_scmd_accept,
  input  logic [SLAVES-1:0]                                     slave_mdata_valid,
  input  logic [SLAVES-1:0][BUS_CONFIG.data_width-1:0]          slave_mdata,
  input  logic [SLAVES-1:0]                                     slave_mdata_last,
  output logic [SLAVES-1:0]                                     slave_sdata_accept,
  // downstream (request_master) port
  output logic                                                  master_mcmd_valid,
  output logic [PZCOREBUS_COMMAND_WIDTH-1:0]                    master_mcmd,
  output logic [BUS_CONFIG.id_width-1:0]                        master_mid,
  output logic [BUS_CONFIG.address_width-1:0]                   master_maddr,
  input  logic                                                  master_scmd_accept,
  output logic                                                  master_mdata_valid,
  output logic [BUS_CONFIG.data_width-1:0]                      master_mdata,
  output logic                                                  master_mdata_last,
  input  logic                                                  master_sdata_accept
);

  pzcorebus_arbiter_state            state_r;
  logic [SELECT_WIDTH-1:0]           grant_index_r;
  logic                              data_done_r;
  logic                              busy_s;
  logic [SLAVES-1:0]                 request_s;
  logic [SLAVES-1:0]                 grant_s;
  logic [SELECT_WIDTH-1:0]           sel_s;
  logic                              release_s;
  logic                              cmd_valid_s;
  logic                              write_s;
  logic                              data_enable_s;
  logic                              cmd_hs_s;
  logic                              last_hs_s;
  logic [BUS_CONFIG.id_width-1:0]    mid_s;

  assign busy_s        = (state_r != ARB);
  assign o_busy        = busy_s;
  assign o_grant_index = grant_index_r;

  // While locked, only the granted port is offered to the search so the
  // search result stays equal to the locked index.
  always_comb begin
    if (busy_s) begin
      request_s                = '0;
      request_s[grant_index_r] = 1'b1;
    end else begin
      request_s = slave_mcmd_valid;
    end
  end

  pzcorebus_round_robin_grant #(
    .N (SLAVES),
    .W (SELECT_WIDTH)
  ) u_grant (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_request (request_s),
    .i_release (release_s),
    .o_grant   (grant_s),
    .o_index   (sel_s)
  );

  // Qualify the selected command and decide whether its data lane is open.
  // Data is blocked in CMD once the last beat has already gone through.
  always_comb begin
    cmd_valid_s = (state_r != DATA) && slave_mcmd_valid[sel_s];
    write_s     = is_write_command(slave_mcmd[sel_s]);
    case (state_r)
      ARB:     data_enable_s = cmd_valid_s && write_s;
      CMD:     data_enable_s = write_s && !data_done_r;
      DATA:    data_enable_s = 1'b1;
      default: data_enable_s = 1'b0;
    endcase
    cmd_hs_s  = cmd_valid_s && master_scmd_accept;
    last_hs_s = data_enable_s && slave_mdata_valid[sel_s] && master_sdata_accept
                && slave_mdata_last[sel_s];
  end

  // Grant release: command done and no write data left outstanding.
  always_comb begin
    case (state_r)
      ARB:     release_s = cmd_hs_s && !(write_s && !last_hs_s);
      CMD:     release_s = cmd_hs_s && !(write_s && !(data_done_r || last_hs_s));
      DATA:    release_s = last_hs_s;
      default: release_s = 1'b0;
    endcase
  end

  // Route the selected port to the master side and stamp its index into mid.
  always_comb begin
    if (EXTERNAL_ENCODE) begin
      mid_s = slave_mid[sel_s];
    end else begin
      mid_s                                 = slave_mid[sel_s];
      mid_s[SELECT_LSB +: SELECT_WIDTH]     = sel_s;
    end
    master_mcmd_valid  = cmd_valid_s;
    master_mcmd        = slave_mcmd[sel_s];
    master_mid         = mid_s;
    master_maddr       = slave_maddr[sel_s];
    master_mdata_valid = data_enable_s && slave_mdata_valid[sel_s];
    master_mdata       = slave_mdata[sel_s];
    master_mdata_last  = slave_mdata_last[sel_s];
    slave_scmd_accept  = grant_s & {SLAVES{cmd_valid_s && master_scmd_accept}};
    slave_sdata_accept = grant_s & {SLAVES{data_enable_s && master_sdata_accept}};
  end

  // Arbitration FSM: lock the grant until command and burst are both done.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_r       <= ARB;
      grant_index_r <= '0;
      data_done_r   <= 1'b0;
    end else begin
      case (state_r)
        ARB: begin
          if (cmd_valid_s) begin
            grant_index_r <= sel_s;
            if (cmd_hs_s) begin
              state_r     <= (write_s && !last_hs_s) ? DATA : ARB;
              data_done_r <= 1'b0;
            end else begin
              state_r     <= CMD;
              data_done_r <= last_hs_s;
            end
          end else begin
            state_r <= ARB;
          end
        end
        CMD: begin
          if (cmd_hs_s) begin
            state_r     <= (write_s && !(data_done_r || last_hs_s)) ? DATA : ARB;
            data_done_r <= 1'b0;
          end else begin
            data_done_r <= data_done_r || last_hs_s;
          end
        end
        DATA: begin
          if (last_hs_s) begin
            state_r <= ARB;
          end else begin
            state_r <= DATA;
          end
        end
        default: begin
          state_r     <= ARB;
          data_done_r <= 1'b0;
        end
      endcase
    end
  end

`ifdef PZCOREBUS_REQUEST_ARBITER_STATS_EN
  // Per-port saturating count of accepted commands; clear beats increment.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_grant_count <= '0;
    end else begin
      for (int k = 0; k < SLAVES; k++) begin
        if (i_stats_clear) begin
          o_grant_count[k] <= 16'h0000;
        end else if (slave_scmd_accept[k] && (o_grant_count[k] != 16'hFFFF)) begin
          o_grant_count[k] <= o_grant_count[k] + 16'h0001;
        end else begin
          o_grant_count[k] <= o_grant_count[k];
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_pzcorebus_request_m_to_1_arbiter.sv
// Directed, table-driven bench for pzcorebus_request_m_to_1_arbiter with
// SLAVES=4, id_width=8 (index field mid[7:6]).
module tb_pzcorebus_request_m_to_1_arbiter;
  import pzcorebus_pkg::*;

  localparam pzcorebus_config CFG = '{id_width: 8, address_width: 16, data_width: 16};

  logic              clk = 1'b0;
  logic              rst_n;
  logic [3:0]        s_valid;
  logic [3:0][2:0]   s_cmd;
  logic [3:0][7:0]   s_mid;
  logic [3:0][15:0]  s_addr;
  logic [3:0]        s_cacc;
  logic [3:0]        s_dvalid;
  logic [3:0][15:0]  s_data;
  logic [3:0]        s_dlast;
  logic [3:0]        s_dacc;
  logic              m_valid;
  logic [2:0]        m_cmd;
  logic [7:0]        m_mid;
  logic [15:0]       m_addr;
  logic              m_cacc;
  logic              m_dvalid;
  logic [15:0]       m_data;
  logic              m_dlast;
  logic              m_dacc;
  logic [1:0]        grant_index;
  logic              busy;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  pzcorebus_request_m_to_1_arbiter #(
    .BUS_CONFIG      (CFG),
    .SLAVES          (4),
    .EXTERNAL_ENCODE (1'b0)
  ) dut (
    .i_clk               (clk),
    .i_rst_n             (rst_n),
    .o_grant_index       (grant_index),
    .o_busy              (busy),
    .slave_mcmd_valid    (s_valid),
    .slave_mcmd          (s_cmd),
    .slave_mid           (s_mid),
    .slave_maddr         (s_addr),
    .slave_scmd_accept   (s_cacc),
    .slave_mdata_valid   (s_dvalid),
    .slave_mdata         (s_data),
    .slave_mdata_last    (s_dlast),
    .slave_sdata_accept  (s_dacc),
    .master_mcmd_valid   (m_valid),
    .master_mcmd         (m_cmd),
    .master_mid          (m_mid),
    .master_maddr        (m_addr),
    .master_scmd_accept  (m_cacc),
    .master_mdata_valid  (m_dvalid),
    .master_mdata        (m_data),
    .master_mdata_last   (m_dlast),
    .master_sdata_accept (m_dacc)
  );

  typedef struct {
    logic [3:0]      valid;
    logic [11:0]     cmd;
    logic            ca;
    logic [3:0]      dv;
    logic [3:0]      dl;
    logic            da;
    logic            emv;
    logic [7:0]      emid;
    logic [3:0]      esa;
    logic            edv;
    logic [3:0]      eda;
    logic            eb;
    logic [1:0]      ei;
  } vec_t;

  vec_t vecs[$];

  function automatic void add_vec(
    input logic [3:0] valid, input logic [11:0] cmd, input logic ca,
    input logic [3:0] dv, input logic [3:0] dl, input logic da,
    input logic emv, input logic [7:0] emid, input logic [3:0] esa,
    input logic edv, input logic [3:0] eda, input logic eb, input logic [1:0] ei);
    vec_t v;
    v.valid = valid; v.cmd = cmd; v.ca = ca; v.dv = dv; v.dl = dl; v.da = da;
    v.emv = emv; v.emid = emid; v.esa = esa; v.edv = edv; v.eda = eda;
    v.eb = eb; v.ei = ei;
    vecs.push_back(v);
  endfunction

  task automatic check(input string what, input int id,
                       input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s (step %0d): got 0x%0h, expected 0x%0h", what, id, act, exp);
    end
  endtask

  task automatic drive_idle();
    s_valid  = 4'b0000;
    s_cmd    = 12'h000;
    s_dvalid = 4'b0000;
    s_dlast  = 4'b0000;
    m_cacc   = 1'b1;
    m_dacc   = 1'b1;
  endtask

  initial begin
    // Port constants; stamped mids: p0 3A, p1 51, p2 85, p3 C7
    s_mid  = {8'h07, 8'h05, 8'h11, 8'hFA};
    s_addr = {16'hA333, 16'hA222, 16'hA111, 16'hA000};
    s_data = {16'hD333, 16'hD222, 16'hD111, 16'hD000};
    rst_n  = 1'b0;
    drive_idle();

    //       valid    cmd      ca    dv       dl       da  | emv   emid   esa      edv   eda      eb    ei
    // idle
    add_vec(4'b0000, 12'h000, 1'b1, 4'b0000, 4'b0000, 1'b1, 1'b0, 8'h00, 4'b0000, 1'b0, 4'b0000, 1'b0, 2'd0);
    // single read, port 2, mid 05 -> 85
    add_vec(4'b0100, 12'h000, 1'b1, 4'b0000, 4'b0000, 1'b1, 1'b1, 8'h85, 4'b0100, 1'b0, 4'b0000, 1'b0, 2'd0);
    // pointer now 3: port 3 wins, then fairness 0,1,2,3,0
    add_vec(4'b1111, 12'h000, 1'b1, 4'b0000, 4'b0000, 1'b1, 1'b1, 8'hC7, 4'b1000, 1'b0, 4'b0000, 1'b0, 2'd0);
    add_vec(4'b1111, 12'h000, 1'b1, 4'b0000, 4'b0000, 1'b1, 1'b1, 8'h3A, 4'b0001, 1'b0, 4'b0000, 1'b0, 2'd0);
    add_vec(4'b1111, 12'h000, 1'b1, 4'b0000, 4'b0000, 1'b1, 1'b1, 8'h51, 4'b0010, 1'b0, 4'b0000, 1'b0, 2'd0);
    add_vec(4'b1111, 12'h000, 1'b1, 4'b0000, 4'b0000, 1'b1, 1'b1, 8'h85, 4'b0100, 1'b0, 4'b0000, 1'b0, 2'd0);
    add_vec(4'b1111, 12'h000, 1'b1, 4'b0000, 4'b0000, 1'b1, 1'b1, 8'hC7, 4'b1000, 1'b0, 4'b0000, 1'b0, 2'd0);
    add_vec(4'b1111, 12'h000, 1'b1, 4'b0000, 4'b0000, 1'b1, 1'b1, 8'h3A, 4'b0001, 1'b0, 4'b0000, 1'b0, 2'd0);
    // write lock: port 1 write + beat 1, ports 0 and 3 reading
    add_vec(4'b1011, 12'h008, 1'b1, 4'b0010, 4'b0000, 1'b1, 1'b1, 8'h51, 4'b0010, 1'b1, 4'b0010, 1'b0, 2'd0);
    add_vec(4'b1001, 12'h008, 1'b1, 4'b0010, 4'b0000, 1'b0, 1'b0, 8'h00, 4'b0000, 1'b1, 4'b0000, 1'b1, 2'd1);
    add_vec(4'b1001, 12'h008, 1'b1, 4'b0010, 4'b0000, 1'b1, 1'b0, 8'h00, 4'b0000, 1'b1, 4'b0010, 1'b1, 2'd1);
    add_vec(4'b1001, 12'h008, 1'b1, 4'b0010, 4'b0000, 1'b0, 1'b0, 8'h00, 4'b0000, 1'b1, 4'b0000, 1'b1, 2'd1);
    add_vec(4'b1001, 12'h008, 1'b1, 4'b0010, 4'b0000, 1'b1, 1'b0, 8'h00, 4'b0000, 1'b1, 4'b0010, 1'b1, 2'd1);
    add_vec(4'b1001, 12'h008, 1'b1, 4'b0010, 4'b0010, 1'b0, 1'b0, 8'h00, 4'b0000, 1'b1, 4'b0000, 1'b1, 2'd1);
    add_vec(4'b1001, 12'h008, 1'b1, 4'b0010, 4'b0010, 1'b1, 1'b0, 8'h00, 4'b0000, 1'b1, 4'b0010, 1'b1, 2'd1);
    // released after last beat: port 3 next
    add_vec(4'b1001, 12'h000, 1'b1, 4'b0000, 4'b0000, 1'b1, 1'b1, 8'hC7, 4'b1000, 1'b0, 4'b0000, 1'b0, 2'd0);
    // early data: port 0 single-beat write, data accepted before command
    add_vec(4'b0001, 12'h001, 1'b0, 4'b0001, 4'b0001, 1'b1, 1'b1, 8'h3A, 4'b0000, 1'b1, 4'b0001, 1'b0, 2'd0);
    add_vec(4'b0001, 12'h001, 1'b1, 4'b0001, 4'b0001, 1'b1, 1'b1, 8'h3A, 4'b0001, 1'b0, 4'b0000, 1'b1, 2'd0);
    add_vec(4'b0000, 12'h000, 1'b1, 4'b0000, 4'b0000, 1'b1, 1'b0, 8'h00, 4'b0000, 1'b0, 4'b0000, 1'b0, 2'd0);
    // backpressure: port 3 held 5 cycles, port 0 waiting
    add_vec(4'b1000, 12'h000, 1'b0, 4'b0000, 4'b0000, 1'b1, 1'b1, 8'hC7, 4'b0000, 1'b0, 4'b0000, 1'b0, 2'd0);
    for (int k = 0; k < 4; k++) begin
      add_vec(4'b1001, 12'h000, 1'b0, 4'b0000, 4'b0000, 1'b1, 1'b1, 8'hC7, 4'b0000, 1'b0, 4'b0000, 1'b1, 2'd3);
    end
    add_vec(4'b1001, 12'h000, 1'b1, 4'b0000, 4'b0000, 1'b1, 1'b1, 8'hC7, 4'b1000, 1'b0, 4'b0000, 1'b1, 2'd3);
    add_vec(4'b0001, 12'h000, 1'b1, 4'b0000, 4'b0000, 1'b1, 1'b1, 8'h3A, 4'b0001, 1'b0, 4'b0000, 1'b0, 2'd0);

    // reset state
    @(negedge clk);
    #2;
    check("reset.busy",       0, 32'(busy),        32'(1'b0));
    check("reset.grant_idx",  0, 32'(grant_index), 32'(2'd0));
    check("reset.mcmd_valid", 0, 32'(m_valid),     32'(1'b0));
    check("reset.mdata_valid",0, 32'(m_dvalid),    32'(1'b0));
    check("reset.scmd_acc",   0, 32'(s_cacc),      32'(4'b0000));
    check("reset.sdata_acc",  0, 32'(s_dacc),      32'(4'b0000));
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      vec_t v;
      v = vecs[i];
      @(negedge clk);
      s_valid  = v.valid;
      s_cmd    = v.cmd;
      m_cacc   = v.ca;
      s_dvalid = v.dv;
      s_dlast  = v.dl;
      m_dacc   = v.da;
      #2;
      check("mcmd_valid", i, 32'(m_valid), 32'(v.emv));
      if (v.emv) begin
        check("mid",   i, 32'(m_mid),  32'(v.emid));
        check("maddr", i, 32'(m_addr), 32'(s_addr[v.emid[7:6]]));
        check("mcmd",  i, 32'(m_cmd),  32'(s_cmd[v.emid[7:6]]));
      end
      check("scmd_accept",  i, 32'(s_cacc),   32'(v.esa));
      check("mdata_valid",  i, 32'(m_dvalid), 32'(v.edv));
      check("sdata_accept", i, 32'(s_dacc),   32'(v.eda));
      check("busy",         i, 32'(busy),     32'(v.eb));
      if (v.eb) begin
        check("grant_index", i, 32'(grant_index), 32'(v.ei));
      end
    end

    // reset mid-burst: port 2 write enters DATA, then reset
    @(negedge clk);
    s_valid  = 4'b0100;
    s_cmd    = 12'h040;
    m_cacc   = 1'b1;
    s_dvalid = 4'b0100;
    s_dlast  = 4'b0000;
    m_dacc   = 1'b1;
    #2;
    check("rst_seq.scmd_accept", 100, 32'(s_cacc),  32'(4'b0100));
    check("rst_seq.mdata",       100, 32'(m_data),  32'(16'hD222));
    check("rst_seq.mdata_last",  100, 32'(m_dlast), 32'(1'b0));
    @(negedge clk);
    s_valid = 4'b0000;
    m_dacc  = 1'b0;
    #2;
    check("rst_seq.busy",      101, 32'(busy),        32'(1'b1));
    check("rst_seq.grant_idx", 101, 32'(grant_index), 32'(2'd2));
    rst_n = 1'b0;
    drive_idle();
    #1;
    check("rst_seq.busy_after",   102, 32'(busy),     32'(1'b0));
    check("rst_seq.mdata_valid",  102, 32'(m_dvalid), 32'(1'b0));
    check("rst_seq.scmd_acc_0",   102, 32'(s_cacc),   32'(4'b0000));
    check("rst_seq.sdata_acc_0",  102, 32'(s_dacc),   32'(4'b0000));
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    // pointer back at 0: port 0 beats port 1
    s_valid = 4'b0011;
    s_cmd   = 12'h000;
    m_cacc  = 1'b1;
    #2;
    check("rst_seq.ptr_mid",  103, 32'(m_mid),  32'(8'h3A));
    check("rst_seq.ptr_acc",  103, 32'(s_cacc), 32'(4'b0001));
    @(negedge clk);
    drive_idle();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
